// File: rtl/alu_defs.sv
// Shared definitions for the sequential ALU: one-hot op codes, FSM state
// encoding and the multiply/divide core mode.
package alu_defs;

  localparam int CTRL_W = 13;

  localparam logic [CTRL_W-1:0] OP_AND  = 13'h0001;
  localparam logic [CTRL_W-1:0] OP_OR   = 13'h0002;
  localparam logic [CTRL_W-1:0] OP_ADD  = 13'h0004;
  localparam logic [CTRL_W-1:0] OP_SUB  = 13'h0008;
  localparam logic [CTRL_W-1:0] OP_MUL  = 13'h0010;
  localparam logic [CTRL_W-1:0] OP_DIV  = 13'h0020;
  localparam logic [CTRL_W-1:0] OP_SHR  = 13'h0040;
  localparam logic [CTRL_W-1:0] OP_SHRA = 13'h0080;
  localparam logic [CTRL_W-1:0] OP_SHL  = 13'h0100;
  localparam logic [CTRL_W-1:0] OP_ROR  = 13'h0200;
  localparam logic [CTRL_W-1:0] OP_ROL  = 13'h0400;
  localparam logic [CTRL_W-1:0] OP_NEG  = 13'h0800;
  localparam logic [CTRL_W-1:0] OP_NOT  = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  // True when exactly one control bit is set.
  function automatic logic is_onehot(input logic [CTRL_W-1:0] v);
    return (v != '0) && ((v & (v - CTRL_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned core: shift-add multiply or restoring divide, one bit
// per clock for WIDTH clocks after load. Operands are magnitudes; signs are
// handled by the caller.
//   MUL: result = a_mag * b_mag (2*WIDTH bits)
//   DIV: result = {a_mag % b_mag, a_mag / b_mag}; a zero divisor yields an
//        all-ones quotient and a remainder equal to the dividend.
module muldiv_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  md_mode_e             mode,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   result,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // hi_q: upper product half / partial remainder
  // lo_q: multiplier being consumed / dividend shifting into quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  md_mode_e         mode_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One iteration step for whichever operation is loaded.
  always_comb begin
    sum     = '0;
    shifted = '0;
    trial   = '0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (mode_q == MD_MUL) begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      shifted = {hi_q, lo_q[WIDTH-1]};
      trial   = shifted - {1'b0, d_q};
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Load operands, then step once per clock until the final iteration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      mode_q <= MD_MUL;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= (mode == MD_MUL) ? b_mag : a_mag;
      d_q    <= (mode == MD_MUL) ? a_mag : b_mag;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      mode_q <= mode;
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_ONE;
      if (cnt_q == LAST_CNT) begin
        run_q <= 1'b0;
      end
    end
  end

  assign result = {hi_q, lo_q};
  assign last   = run_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU. Logic/add/shift/rotate ops complete in one cycle;
// signed MUL/DIV iterate WIDTH cycles in muldiv_seq, then get a sign fix.
// Handshake: start is sampled only in IDLE; busy is high from the accepted
// start until (and including) the single-cycle done pulse; C/dz/err hold
// until the next accepted start.
module alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CTRL_W-1:0]    control,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 busy,
  output logic                 done,
  output logic                 dz,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam logic [WIDTH-1:0]   WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2*WIDTH-1:0]  c_q, c_d;
  logic                dz_q, dz_d;
  logic                err_q, err_d;

  logic                core_load;
  logic                core_last;
  md_mode_e            core_mode;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [2*WIDTH-1:0]  core_res;

  logic [WIDTH-1:0]    alu_lo;
  logic [SHW-1:0]      shamt;
  logic [SHW-1:0]      rot_amt;
  logic                b_big;

  logic [2*WIDTH-1:0]  mul_res;
  logic [WIDTH-1:0]    quo_raw, rem_raw;
  logic [WIDTH-1:0]    quo_fix, rem_fix;

  // Magnitudes feed the core directly at the accepted start edge.
  assign a_mag     = A[WIDTH-1] ? (~A + ONE_W) : A;
  assign b_mag     = B[WIDTH-1] ? (~B + ONE_W) : B;
  assign core_mode = (control == OP_MUL) ? MD_MUL : MD_DIV;

  muldiv_seq #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (core_load),
    .mode    (core_mode),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .result  (core_res),
    .last    (core_last)
  );

  // Single-cycle datapath, evaluated on the operands presented with start.
  always_comb begin
    shamt   = B[SHW-1:0];
    rot_amt = SHW'(32'(B[SHW-1:0]) % WIDTH);
    b_big   = (B >= WIDTH_V);
    alu_lo  = '0;
    case (control)
      OP_AND:  alu_lo = A & B;
      OP_OR:   alu_lo = A | B;
      OP_ADD:  alu_lo = A + B;
      OP_SUB:  alu_lo = A - B;
      OP_SHR:  alu_lo = b_big ? '0 : (A >> shamt);
      OP_SHRA: alu_lo = b_big ? {WIDTH{A[WIDTH-1]}} : ($signed(A) >>> shamt);
      OP_SHL:  alu_lo = b_big ? '0 : (A << shamt);
      OP_ROR:  alu_lo = (A >> rot_amt) | (A << (WIDTH - int'(rot_amt)));
      OP_ROL:  alu_lo = (A << rot_amt) | (A >> (WIDTH - int'(rot_amt)));
      OP_NEG:  alu_lo = ~A + ONE_W;
      OP_NOT:  alu_lo = ~A;
      default: alu_lo = '0;
    endcase
  end

  // Sign correction of the raw magnitude result using the captured operands.
  always_comb begin
    mul_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~core_res + ONE_2W) : core_res;
    quo_raw = core_res[WIDTH-1:0];
    rem_raw = core_res[2*WIDTH-1:WIDTH];
    quo_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~quo_raw + ONE_W) : quo_raw;
    rem_fix = a_q[WIDTH-1] ? (~rem_raw + ONE_W) : rem_raw;
  end

  // FSM next state and output-register updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    dz_d      = dz_q;
    err_d     = err_q;
    core_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = control;
          a_d   = A;
          b_d   = B;
          dz_d  = 1'b0;
          if (!is_onehot(control)) begin
            err_d   = 1'b1;
            c_d     = '0;
            state_d = ST_DONE;
          end else if ((control == OP_MUL) || (control == OP_DIV)) begin
            err_d     = 1'b0;
            c_d       = '0;
            core_load = 1'b1;
            state_d   = ST_ITER;
          end else begin
            err_d   = 1'b0;
            c_d     = {{WIDTH{1'b0}}, alu_lo};
            state_d = ST_DONE;
          end
        end
      end
      ST_ITER: begin
        if (core_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (op_q == OP_MUL) begin
          c_d = mul_res;
        end else if (b_q == '0) begin
          dz_d = 1'b1;
          c_d  = {a_q, {WIDTH{1'b1}}};
        end else begin
          c_d = {rem_fix, quo_fix};
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
    end
  end

  assign C         = c_q;
  assign dz        = dz_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): directed scenarios plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_seq;

  localparam logic [12:0] C_AND  = 13'h0001;
  localparam logic [12:0] C_OR   = 13'h0002;
  localparam logic [12:0] C_ADD  = 13'h0004;
  localparam logic [12:0] C_SUB  = 13'h0008;
  localparam logic [12:0] C_MUL  = 13'h0010;
  localparam logic [12:0] C_DIV  = 13'h0020;
  localparam logic [12:0] C_SHR  = 13'h0040;
  localparam logic [12:0] C_SHRA = 13'h0080;
  localparam logic [12:0] C_SHL  = 13'h0100;
  localparam logic [12:0] C_ROR  = 13'h0200;
  localparam logic [12:0] C_ROL  = 13'h0400;
  localparam logic [12:0] C_NEG  = 13'h0800;
  localparam logic [12:0] C_NOT  = 13'h1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] control = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [63:0] C;
  logic        busy, done, dz, err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [63:0] obs_c;
  logic        obs_dz, obs_err;
  int          obs_lat, obs_busy;

  logic [65:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .control   (control),
    .A         (A),
    .B         (B),
    .C         (C),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Reference model: returns {err, dz, C}.
  function automatic logic [65:0] model(input logic [12:0] ctrl,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] lo;
    longint q, r, p;
    int n;
    sa = a;
    sb = b;
    lo = '0;
    if ($countones(ctrl) != 1) return {2'b10, 64'h0};
    if (ctrl == C_MUL) begin
      p = longint'(sa) * longint'(sb);
      return {2'b00, p[63:0]};
    end
    if (ctrl == C_DIV) begin
      if (b == 32'h0) return {2'b01, a, 32'hFFFF_FFFF};
      q = longint'(sa) / longint'(sb);
      r = longint'(sa) % longint'(sb);
      return {2'b00, r[31:0], q[31:0]};
    end
    n = int'(b % 32);
    if (ctrl == C_AND)  lo = a & b;
    if (ctrl == C_OR)   lo = a | b;
    if (ctrl == C_ADD)  lo = a + b;
    if (ctrl == C_SUB)  lo = a - b;
    if (ctrl == C_SHR)  lo = (b >= 32) ? 32'h0 : (a >> b);
    if (ctrl == C_SHRA) lo = (b >= 32) ? {32{a[31]}} : 32'(sa >>> b);
    if (ctrl == C_SHL)  lo = (b >= 32) ? 32'h0 : (a << b);
    if (ctrl == C_ROR)  lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
    if (ctrl == C_ROL)  lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
    if (ctrl == C_NEG)  lo = 32'h0 - a;
    if (ctrl == C_NOT)  lo = ~a;
    return {2'b00, 32'h0, lo};
  endfunction

  function automatic int model_lat(input logic [12:0] ctrl);
    return ((ctrl == C_MUL) || (ctrl == C_DIV)) ? 34 : 1;
  endfunction

  // Driver: issue one op, scramble inputs afterwards, wait (bounded) for done.
  task automatic run_op(input logic [12:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    control = ctrl;
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    control = 13'($urandom_range(0, 8191));
    obs_lat = 1;
    obs_busy = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && obs_lat < 100) begin
      @(negedge clk);
      obs_lat++;
      if (busy === 1'b1) obs_busy++;
    end
    obs_c = C;
    obs_dz = dz;
    obs_err = err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({C, busy, done, dz, err} !== 68'h0) begin
      errors++;
      $display("FAIL reset_outputs: got C=%h busy=%b done=%b dz=%b err=%b, want all 0",
               C, busy, done, dz, err);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    run_op(C_ADD, 32'h7FFF_FFFF, 32'h1);
    checks++;
    if (obs_c !== 64'h0000_0000_8000_0000 || obs_err !== 1'b0 || obs_lat != 1) begin
      errors++;
      $display("FAIL add_overflow: got C=%h err=%b lat=%0d, want C=0000000080000000 err=0 lat=1",
               obs_c, obs_err, obs_lat);
    end
  endtask

  task automatic test_mul();
    run_op(C_MUL, 32'hFFFF_FFFD, 32'd7);
    checks++;
    if (obs_c !== 64'hFFFF_FFFF_FFFF_FFEB || obs_lat != 34 || obs_busy != 34) begin
      errors++;
      $display("FAIL mul_neg3x7: got C=%h lat=%0d busy=%0d, want C=ffffffffffffffeb lat=34 busy=34",
               obs_c, obs_lat, obs_busy);
    end
  endtask

  task automatic test_div();
    run_op(C_DIV, 32'hFFFF_FFEF, 32'd5);
    checks++;
    if (obs_c !== {32'hFFFF_FFFE, 32'hFFFF_FFFD} || obs_dz !== 1'b0 || obs_lat != 34) begin
      errors++;
      $display("FAIL div_neg17_5: got C=%h dz=%b lat=%0d, want C=fffffffefffffffd dz=0 lat=34",
               obs_c, obs_dz, obs_lat);
    end
    run_op(C_DIV, 32'd9, 32'd0);
    checks++;
    if (obs_c !== {32'h0000_0009, 32'hFFFF_FFFF} || obs_dz !== 1'b1 || obs_lat != 34) begin
      errors++;
      $display("FAIL div_by_zero: got C=%h dz=%b lat=%0d, want C=00000009ffffffff dz=1 lat=34",
               obs_c, obs_dz, obs_lat);
    end
  endtask

  task automatic test_shifts();
    logic [12:0] ct[6];
    logic [31:0] av[6];
    logic [31:0] bv[6];
    logic [31:0] ev[6];
    ct = '{C_ROR, C_SHRA, C_SHL, C_ROL, C_SHR, C_ROR};
    av = '{32'h8000_0001, 32'h8000_0000, 32'h1, 32'h8000_0001, 32'hF000_0000, 32'h1234_5678};
    bv = '{32'd36, 32'd40, 32'd32, 32'd1, 32'd31, 32'd32};
    ev = '{32'h1800_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0003, 32'h1, 32'h1234_5678};
    for (int i = 0; i < 6; i++) begin
      run_op(ct[i], av[i], bv[i]);
      checks++;
      if (obs_c !== {32'h0, ev[i]} || obs_lat != 1) begin
        errors++;
        $display("FAIL shift_vec%0d: got C=%h lat=%0d, want C=%h lat=1",
                 i, obs_c, obs_lat, {32'h0, ev[i]});
      end
    end
  endtask

  task automatic test_illegal();
    run_op(13'h0003, 32'h55, 32'hAA);
    checks++;
    if (obs_err !== 1'b1 || obs_c !== 64'h0 || obs_lat != 1) begin
      errors++;
      $display("FAIL illegal_ctrl: got err=%b C=%h lat=%0d, want err=1 C=0 lat=1",
               obs_err, obs_c, obs_lat);
    end
    run_op(13'h0000, 32'h1, 32'h1);
    checks++;
    if (obs_err !== 1'b1 || obs_c !== 64'h0) begin
      errors++;
      $display("FAIL zero_ctrl: got err=%b C=%h, want err=1 C=0", obs_err, obs_c);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    @(negedge clk);
    control = C_MUL; A = 32'hFFFF_FFFD; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin
        control = C_ADD; A = 32'd1; B = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (C !== 64'hFFFF_FFFF_FFFF_FFEB || lat != 34) begin
      errors++;
      $display("FAIL start_in_iter: got C=%h lat=%0d, want C=ffffffffffffffeb lat=34", C, lat);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_not_queued: got %0d busy/done cycles after MUL, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int m;
    @(negedge clk);
    control = C_ADD; A = 32'd10; B = 32'd20; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 10);
    checks++;
    if (C !== 64'd30 || n != 1) begin
      errors++;
      $display("FAIL b2b_first: got C=%h lat=%0d, want C=30 lat=1", C, n);
    end
    control = C_SUB; A = 32'd100; B = 32'd5;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (done !== 1'b1 && m < 10);
    start = 1'b0;
    checks++;
    if (C !== 64'd95 || m != 2) begin
      errors++;
      $display("FAIL b2b_second: got C=%h interval=%0d, want C=95 interval=2", C, m);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    control = C_DIV; A = 32'd1000; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({C, busy, done, dz, err} !== 68'h0) begin
      errors++;
      $display("FAIL reset_midop: got C=%h busy=%b done=%b dz=%b err=%b, want all 0",
               C, busy, done, dz, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(C_ADD, 32'd2, 32'd3);
    checks++;
    if (obs_c !== 64'd5 || obs_lat != 1) begin
      errors++;
      $display("FAIL add_after_reset: got C=%h lat=%0d, want C=5 lat=1", obs_c, obs_lat);
    end
  endtask

  task automatic test_random();
    logic [12:0] ct;
    logic [31:0] a, b;
    logic [65:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) ct = 13'($urandom_range(0, 8191));
      else ct = 13'(1) << $urandom_range(0, 12);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 40);
        1: b = 32'h0;
        default: b = $urandom;
      endcase
      exp_q.push_back(model(ct, a, b));
      run_op(ct, a, b);
      exp_v = exp_q.pop_front();
      checks++;
      if ({obs_err, obs_dz, obs_c} !== exp_v || obs_lat != model_lat(ct) && exp_v[65] == 1'b0
          || exp_v[65] == 1'b1 && obs_lat != 1) begin
        errors++;
        $display("FAIL random%0d ctrl=%h A=%h B=%h: got err=%b dz=%b C=%h lat=%0d, want err=%b dz=%b C=%h",
                 i, ct, a, b, obs_err, obs_dz, obs_c, obs_lat, exp_v[65], exp_v[64], exp_v[63:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_mul();
    test_div();
    test_shifts();
    test_illegal();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that replaces the purely combinational datapath ALU. It accepts an operation on a start strobe and completes logic, add, shift and rotate operations in one cycle. Signed multiply and signed divide run iteratively over WIDTH cycles and report completion with a done pulse. It sits between the register-file operand latches (A/B) and the Z/HI/LO result registers, and the control unit sequences it through a start/busy/done handshake.

## Interface
- WIDTH, 32: operand width; must be even and ≥ 4.
- SHW, $clog2(WIDTH): shift-amount bits used by shifts and rotates.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- control  in  13  one-hot op select: bit0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT.
- A, B  in  WIDTH  operands, two's complement where signed.
- C  out  2*WIDTH  result register.
- busy  out  1  high from accepted start until done.
- done  out  1  single-cycle completion pulse.
- dz  out  1  divide-by-zero flag, valid with done.
- err  out  1  illegal control (zero or not one-hot), valid with done.

## Operation
- Operand capture: A, B and control are registered on the accepted start edge. Later input changes do not affect the operation in flight.
- Single-cycle ops write the result to C[WIDTH-1:0] and zero C[2W-1:W].
- ADD/SUB: modulo 2^WIDTH; carry is discarded.
- NEG: ~A+1. NOT: ~A.
- SHR/SHL: logical shifts by the full B value. If B ≥ WIDTH the result is 0.
- SHRA: arithmetic right shift. If B ≥ WIDTH the result is all sign bits.
- ROR/ROL: rotate by B mod WIDTH, using B[SHW-1:0]. A rotate by 0 returns A.
- MUL: signed A×B, full 2*WIDTH product into C. Implemented as magnitude shift-add with final sign fix.
- DIV: signed restoring division, truncating toward zero.
  - C = {remainder, quotient}; HI holds the remainder, LO the quotient.
  - The remainder takes the sign of the dividend.
- DIV with B=0: dz=1, quotient all ones, remainder = A. Completes with normal latency.
- Illegal control: err=1, C=0, completes as a single-cycle op.
- FSM states:
  - IDLE: on start, go to DONE for single-cycle/illegal ops, or to ITER for MUL/DIV.
  - ITER: runs WIDTH cycles on a counter, then goes to FIX.
  - FIX: sign correction and write to C, then goes to DONE.
  - DONE: pulses done, then returns to IDLE.
- busy is high in ITER, FIX and DONE. It is low in IDLE.
- start outside IDLE is ignored and is not queued.
- C, dz and err hold their values until the next accepted start.
- Reset value of every output is 0: C, busy, done, dz, err. The state is IDLE.
- Reset mid-operation aborts immediately: counter cleared, partial result discarded, C=0.

## Timing
- Start accepted at edge t. Single-cycle ops: C valid and done=1 during cycle t+1.
- MUL/DIV: ITER covers edges t+1..t+WIDTH, FIX is at t+WIDTH+1, done=1 in cycle t+WIDTH+2. That is 34 cycles for WIDTH=32.
- Back-to-back: start may be asserted during the done cycle. It is accepted at the next edge, when the FSM is back in IDLE, so the minimum issue interval is 2 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared header alu_defs:
  - one-hot op constants (OP_AND…OP_NOT);
  - FSM state encodings;
  - control width (13).
- Sub-module muldiv_seq: iterative unsigned shift-add / restoring-subtract core.
  - Inputs: mode, magnitudes, load.
  - Outputs: 2*WIDTH raw result, last-iteration strobe.
- The top level holds the FSM, the single-cycle datapath, sign fix-up and the output registers.

## Test plan
- WIDTH=32, ADD A=0x7FFFFFFF, B=1 → done one cycle after start, C=0x00000000_80000000, err=0.
- MUL A=-3, B=7 → done 34 cycles after start, C=0xFFFFFFFF_FFFFFFEB, busy high for 34 cycles.
- DIV A=-17, B=5 → C={0xFFFFFFFE, 0xFFFFFFFD}. DIV A=9, B=0 → dz=1, C={0x00000009, 0xFFFFFFFF}.
- Shifts and rotates:
  - ROR A=0x80000001, B=36 → 0x18000000.
  - SHRA A=0x80000000, B=40 → 0xFFFFFFFF.
  - SHL A=1, B=32 → 0.
- control=0x0003 → err=1, C=0 one cycle later. start pulsed during MUL ITER is ignored, and the MUL result is unchanged.
- reset_n low at cycle 10 of a DIV → all outputs 0 immediately. A subsequent ADD 2+3 returns C=5 one cycle after its start.
